// File: rtl/rpn_pkg.sv
// Shared types for the RPN engine: opcodes, error codes, FSM states and
// the operand-count helper used by the sequencer.
package rpn_pkg;

  typedef enum logic [3:0] {
    OP_PUSH = 4'd0,
    OP_POP  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SLTU = 4'd6,
    OP_MUL  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_NOR  = 4'd10,
    OP_XOR  = 4'd11,
    OP_SWAP = 4'd12,
    OP_DUP  = 4'd13,
    OP_CLR  = 4'd14,
    OP_BAD  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_UNDER = 2'd1,
    ERR_OVER  = 2'd2,
    ERR_BADOP = 2'd3
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CAPT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Number of stack entries an opcode consumes before it can execute.
  function automatic logic [1:0] min_depth(op_e op);
    case (op)
      OP_PUSH, OP_CLR, OP_BAD: min_depth = 2'd0;
      OP_POP, OP_DUP:          min_depth = 2'd1;
      default:                 min_depth = 2'd2;
    endcase
  endfunction

  // Ops that finish in the accept cycle without visiting CAPT/COMMIT.
  function automatic logic is_stack_op(op_e op);
    is_stack_op = (op == OP_PUSH) || (op == OP_POP) ||
                  (op == OP_DUP)  || (op == OP_CLR);
  endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU: a = top of stack, b = next. Result replaces both.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] y
);

  logic [2*WIDTH-1:0] prod;
  logic               shift_oob;

  // Full-width product; only the low half is kept (modulo 2^WIDTH).
  assign prod      = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, a};
  // Any shift of WIDTH or more clears the value rather than wrapping the amount.
  assign shift_oob = (a >= WIDTH'(WIDTH));

  // Opcode decode; stack-only opcodes never reach here, so they yield 0.
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = b + a;
      OP_SUB:  y = b - a;
      OP_SLL:  y = shift_oob ? '0 : (b << a);
      OP_SRL:  y = shift_oob ? '0 : (b >> a);
      OP_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_MUL:  y = prod[WIDTH-1:0];
      OP_AND:  y = b & a;
      OP_OR:   y = b | a;
      OP_NOR:  y = ~(b | a);
      OP_XOR:  y = b ^ a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_engine.sv
// RPN calculator core: command sequencer, DEPTH x WIDTH register stack and
// ALU. Stack ops retire in the accept cycle; binary ops and SWAP go through
// CAPT (latch operands) and COMMIT (write back) so the ALU sees registered
// operands and the stack update is a single atomic write.
module rpn_engine
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  op_e                      cmd_op,
  input  logic [WIDTH-1:0]         cmd_val,
  output logic [WIDTH-1:0]         top,
  output logic [WIDTH-1:0]         next,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     busy,
  output logic                     err,
  output err_e                     err_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  // Entry depth_q-1 is the top of stack; entries at and above depth_q are stale.
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [DW-1:0]    depth_q;
  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             err_q;
  err_e             err_code_q;

  logic [AW-1:0]    idx_top, idx_nxt, idx_new;
  logic             accept;
  err_e             chk_err;
  logic [WIDTH-1:0] alu_y;

  assign idx_top = AW'(depth_q - DW'(1));
  assign idx_nxt = AW'(depth_q - DW'(2));
  assign idx_new = AW'(depth_q);

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  assign top      = (depth_q != '0)      ? stack_q[idx_top] : '0;
  assign next     = (depth_q >= DW'(2))  ? stack_q[idx_nxt] : '0;
  assign depth    = depth_q;
  assign err      = err_q;
  assign err_code = err_code_q;

  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  // Command legality check and next-state decode.
  always_comb begin
    chk_err = ERR_NONE;
    state_d = state_q;
    if (cmd_op == OP_BAD)
      chk_err = ERR_BADOP;
    else if (depth_q < DW'(min_depth(cmd_op)))
      chk_err = ERR_UNDER;
    else if (((cmd_op == OP_PUSH) || (cmd_op == OP_DUP)) && (depth_q == DW'(DEPTH)))
      chk_err = ERR_OVER;

    case (state_q)
      ST_IDLE:   if (accept && (chk_err == ERR_NONE) && !is_stack_op(cmd_op))
                   state_d = ST_CAPT;
      ST_CAPT:   state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Stack, operand and error registers; reset discards any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      depth_q    <= '0;
      op_q       <= OP_PUSH;
      a_q        <= '0;
      b_q        <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (chk_err != ERR_NONE) begin
              err_q      <= 1'b1;
              err_code_q <= chk_err;
            end else begin
              op_q <= cmd_op;
              case (cmd_op)
                OP_PUSH: begin
                  stack_q[idx_new] <= cmd_val;
                  depth_q          <= depth_q + DW'(1);
                end
                OP_DUP: begin
                  stack_q[idx_new] <= stack_q[idx_top];
                  depth_q          <= depth_q + DW'(1);
                end
                OP_POP: depth_q <= depth_q - DW'(1);
                OP_CLR: begin
                  depth_q    <= '0;
                  err_q      <= 1'b0;
                  err_code_q <= ERR_NONE;
                end
                default: ;
              endcase
            end
          end
        end
        ST_CAPT: begin
          a_q <= stack_q[idx_top];
          b_q <= stack_q[idx_nxt];
        end
        ST_COMMIT: begin
          if (op_q == OP_SWAP) begin
            stack_q[idx_top] <= b_q;
            stack_q[idx_nxt] <= a_q;
          end else begin
            stack_q[idx_nxt] <= alu_y;
            depth_q          <= depth_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_engine.sv
// Scoreboard bench for rpn_engine: a queue-based stack model predicts the
// visible state after each command; a monitor checks it once the DUT is idle.
module tb_rpn_engine;
  import rpn_pkg::*;

  localparam int W = 16;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  op_e           cmd_op;
  logic [W-1:0]  cmd_val;
  logic [W-1:0]  top, next;
  logic [3:0]    depth;
  logic          busy, err;
  err_e          err_code;

  rpn_engine #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_val(cmd_val), .top(top), .next(next),
    .depth(depth), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    top;
    int    nxt;
    int    depth;
    int    err;
    int    code;
    int    lat;
    string nm;
  } exp_t;

  exp_t      sbq[$];
  int        mstk[$];   // front = top of stack
  int        merr, mcode;
  int        ntests = 0, nfail = 0;
  bit        pend = 0;

  task automatic chk(string nm, longint act, longint exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ref_alu(int op, int a, int b);
    longint r;
    case (op)
      2:  r = longint'(b) + a;
      3:  r = longint'(b) - a;
      4:  r = (a >= W) ? 0 : (longint'(b) << a);
      5:  r = (a >= W) ? 0 : (longint'(b) >> a);
      6:  r = (a < b) ? 1 : 0;
      7:  r = longint'(b) * longint'(a);
      8:  r = b & a;
      9:  r = b | a;
      10: r = ~(b | a);
      11: r = b ^ a;
      default: r = 0;
    endcase
    return int'(r & 64'hFFFF);
  endfunction

  function automatic void model_reset();
    mstk.delete();
    merr  = 0;
    mcode = 0;
  endfunction

  function automatic exp_t snap(int lat, string nm);
    exp_t e;
    e.top   = (mstk.size() > 0) ? mstk[0] : 0;
    e.nxt   = (mstk.size() > 1) ? mstk[1] : 0;
    e.depth = mstk.size();
    e.err   = merr;
    e.code  = mcode;
    e.lat   = lat;
    e.nm    = nm;
    return e;
  endfunction

  // Behavioural effect of one command; returns the expected busy cycles.
  function automatic int model_apply(int op, int v);
    int need, a, b, lat;
    lat  = 0;
    need = (op == 0 || op == 14 || op == 15) ? 0 : (op == 1 || op == 13) ? 1 : 2;
    if (op == 15) begin merr = 1; mcode = 3; end
    else if (mstk.size() < need) begin merr = 1; mcode = 1; end
    else if ((op == 0 || op == 13) && mstk.size() == D) begin merr = 1; mcode = 2; end
    else begin
      case (op)
        0:  mstk.push_front(v & 16'hFFFF);
        1:  void'(mstk.pop_front());
        13: mstk.push_front(mstk[0]);
        14: begin mstk.delete(); merr = 0; mcode = 0; end
        12: begin a = mstk[0]; mstk[0] = mstk[1]; mstk[1] = a; lat = 2; end
        default: begin
          a = mstk.pop_front();
          b = mstk.pop_front();
          mstk.push_front(ref_alu(op, a, b));
          lat = 2;
        end
      endcase
    end
    return lat;
  endfunction

  // Offer one command and hold it until the DUT accepts it.
  task automatic issue_raw(int op, int v);
    bit acc;
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op_e'(op);
    cmd_val   = W'(v);
    n = 0;
    forever begin
      #3 acc = cmd_ready;
      @(posedge clk);
      if (acc) break;
      n++;
      if (n > 50) begin
        ntests++; nfail++;
        $display("FAIL accept_timeout: op %0d never accepted", op);
        break;
      end
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic issue(int op, int v, string nm);
    int lat;
    lat = model_apply(op, v);
    sbq.push_back(snap(lat, nm));
    issue_raw(op, v);
  endtask

  // Monitor: sampled mid-low-phase; a command completes when the engine is idle again.
  initial begin
    int   bc;
    exp_t e;
    bc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (pend && !busy) begin
        pend = 1'b0;
        if (sbq.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL sb_empty: command completed with nothing expected");
        end else begin
          e = sbq.pop_front();
          chk({e.nm, " top"},   top,      e.top);
          chk({e.nm, " next"},  next,     e.nxt);
          chk({e.nm, " depth"}, depth,    e.depth);
          chk({e.nm, " err"},   err,      e.err);
          chk({e.nm, " code"},  err_code, e.code);
          chk({e.nm, " busy_cycles"}, bc, e.lat);
          chk({e.nm, " ready"}, cmd_ready, 1);
        end
      end else if (pend) begin
        bc++;
      end
      if (cmd_valid && cmd_ready && !rst) begin
        pend = 1'b1;
        bc   = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, op, v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_PUSH; cmd_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #2;
    chk("reset top", top, 0);
    chk("reset next", next, 0);
    chk("reset depth", depth, 0);
    chk("reset err", err, 0);
    chk("reset code", err_code, 0);
    chk("reset ready", cmd_ready, 1);
    chk("reset busy", busy, 0);

    // ADD basic with 2-cycle busy window
    issue(0, 7, "push7"); issue(0, 5, "push5"); issue(2, 0, "add");
    // SUB and wrap, SLTU
    issue(14, 0, "clr1");
    issue(0, 3, "p3"); issue(0, 2, "p2"); issue(3, 0, "sub");
    issue(0, 2, "p2b"); issue(3, 0, "sub_wrap");
    issue(0, 1, "p1"); issue(0, 16'hFFFF, "pffff"); issue(6, 0, "sltu");
    // Shifts including out-of-range amount
    issue(14, 0, "clr2");
    issue(0, 1, "p1s"); issue(0, 20, "p20"); issue(4, 0, "sll_oob");
    issue(0, 16'h8000, "p8000"); issue(0, 15, "p15"); issue(5, 0, "srl15");
    // Overflow at full stack, then a binary op at full depth
    issue(14, 0, "clr3");
    for (int i = 1; i <= 8; i++) issue(0, i, "fill");
    issue(0, 9, "push_over");
    issue(13, 0, "dup_over");
    issue(7, 0, "mul_full");
    issue(14, 0, "clr_err");
    // Underflow and bad opcode
    issue(1, 0, "pop_empty");
    issue(13, 0, "dup_empty");
    issue(0, 4, "p4"); issue(2, 0, "add_under");
    issue(12, 0, "swap_under");
    issue(15, 0, "badop");
    issue(14, 0, "clr4");
    // SWAP, then reset while MUL is in CAPT
    issue(0, 16'hA, "pA"); issue(0, 16'hB, "pB"); issue(12, 0, "swap");
    model_reset();
    sbq.push_back(snap(1, "rst_mid"));
    issue_raw(7, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;

    // Random command stream
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      op = 0;
      else if (r < 37) op = 14;
      else             op = $urandom_range(1, 15);
      v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : $urandom_range(0, 65535);
      issue(op, v, "rand");
    end

    for (int n = 0; n < 20 && (sbq.size() != 0 || pend); n++) @(posedge clk);
    if (sbq.size() != 0 || pend) begin
      ntests++; nfail++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
